// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU control encodings and NZCV flag bit positions.
//   ALU_ADD/ALU_SUB/ALU_AND/ALU_ORR : 2-bit op codes seen on reqN_op
//   FLG_N/FLG_Z/FLG_C/FLG_V         : bit indices inside a {N,Z,C,V} nibble
package alu_ctrl_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu.sv
// alu: single combinational 32-bit ALU.
//   a, b   in  32  operands
//   op     in  2   ALU_ADD / ALU_SUB / ALU_AND / ALU_ORR
//   result out 32  operation result
//   flags  out 4   {N,Z,C,V}; C is bit 32 of the 33-bit add/sub (borrow on SUB),
//                  C and V are forced to 0 for logical ops
module alu
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic [32:0] wide_s;
  logic        carry_s;
  logic        ovf_s;

  // Operation select plus flag generation.
  always_comb begin
    wide_s  = 33'd0;
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    result  = 32'd0;
    case (op)
      ALU_ADD: begin
        wide_s  = {1'b0, a} + {1'b0, b};
        result  = wide_s[31:0];
        carry_s = wide_s[32];
        ovf_s   = (a[31] == b[31]) & (wide_s[31] != a[31]);
      end
      ALU_SUB: begin
        wide_s  = {1'b0, a} - {1'b0, b};
        result  = wide_s[31:0];
        carry_s = wide_s[32];
        ovf_s   = (a[31] != b[31]) & (wide_s[31] != a[31]);
      end
      ALU_AND: result = a & b;
      ALU_ORR: result = a | b;
      default: result = 32'd0;
    endcase
    flags        = 4'd0;
    flags[FLG_N] = result[31];
    flags[FLG_Z] = (result == 32'd0);
    flags[FLG_C] = carry_s;
    flags[FLG_V] = ovf_s;
  end

endmodule

// File: rtl/alu_share_arbiter_rsp_buf.sv
// alu_rsp_buf: one-entry registered result/flag buffer with valid/ready.
//   clk, rst_n   clock, async active-low reset
//   load         accept a new entry this edge (caller guarantees room)
//   load_result  32-bit result to capture
//   load_flags   4-bit {N,Z,C,V} to capture
//   rsp_ready    consumer takes the entry
//   rsp_valid    entry present
//   rsp_result   buffered result (stable while valid & ~ready)
//   rsp_flags    buffered flags
module alu_rsp_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_result,
  input  logic [3:0]  load_flags,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags
);

  // Valid bit: load wins over drain so drain+accept keeps the entry occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid;
    end
  end

  // Payload only changes on load, so it is stable while waiting for ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= 32'd0;
      rsp_flags  <= 4'd0;
    end else if (load) begin
      rsp_result <= load_result;
      rsp_flags  <= load_flags;
    end else begin
      rsp_result <= rsp_result;
      rsp_flags  <= rsp_flags;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two requesters with round-robin
// arbitration, a one-entry response buffer per requester and the NZCV register.
//   reqN_valid/ready/a/b/op/setflags  request side, N = 0, 1
//   rspN_valid/ready/result/flags     response side, one cycle after accept
//   flags                             architectural NZCV register
//   busy                              either response buffer occupied
module alu_share_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_INIT = 4'b0000,
  parameter int         FIRST_PRI = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req0_setflags,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_op,
  input  logic        req1_setflags,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic [3:0]  rsp0_flags,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [3:0]  rsp1_flags,
  output logic [3:0]  flags,
  output logic        busy
);

  logic [1:0]  elig_s;
  logic [1:0]  grant_s;
  logic [31:0] alu_a_s;
  logic [31:0] alu_b_s;
  logic [1:0]  alu_op_s;
  logic        setflags_s;
  logic [31:0] alu_res_s;
  logic [3:0]  alu_flags_s;
  logic        rr_ptr_r;   // requester that wins the next contested cycle
  logic [3:0]  flags_r;

  // Eligibility and grant: a full buffer that drains this cycle still accepts.
  always_comb begin
    elig_s[0] = req0_valid & (~rsp0_valid | rsp0_ready);
    elig_s[1] = req1_valid & (~rsp1_valid | rsp1_ready);
    grant_s   = 2'b00;
    case (elig_s)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = rr_ptr_r ? 2'b10 : 2'b01;
      default: grant_s = 2'b00;
    endcase
  end

  assign req0_ready = grant_s[0];
  assign req1_ready = grant_s[1];

  // Operand mux: requester 0 drives the ALU unless requester 1 is granted.
  always_comb begin
    if (grant_s[1]) begin
      alu_a_s    = req1_a;
      alu_b_s    = req1_b;
      alu_op_s   = req1_op;
      setflags_s = req1_setflags;
    end else begin
      alu_a_s    = req0_a;
      alu_b_s    = req0_b;
      alu_op_s   = req0_op;
      setflags_s = req0_setflags;
    end
  end

  alu u_alu (
    .a      (alu_a_s),
    .b      (alu_b_s),
    .op     (alu_op_s),
    .result (alu_res_s),
    .flags  (alu_flags_s)
  );

  // Round-robin pointer: after a grant, priority passes to the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= (FIRST_PRI != 0) ? 1'b1 : 1'b0;
    end else if (grant_s[0]) begin
      rr_ptr_r <= 1'b1;
    end else if (grant_s[1]) begin
      rr_ptr_r <= 1'b0;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // NZCV register: written only by a granted op that asks for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= FLAG_INIT;
    end else if ((grant_s != 2'b00) && setflags_s) begin
      flags_r <= alu_flags_s;
    end else begin
      flags_r <= flags_r;
    end
  end

  assign flags = flags_r;
  assign busy  = rsp0_valid | rsp1_valid;

  alu_rsp_buf u_rsp0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (grant_s[0]),
    .load_result (alu_res_s),
    .load_flags  (alu_flags_s),
    .rsp_ready   (rsp0_ready),
    .rsp_valid   (rsp0_valid),
    .rsp_result  (rsp0_result),
    .rsp_flags   (rsp0_flags)
  );

  alu_rsp_buf u_rsp1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (grant_s[1]),
    .load_result (alu_res_s),
    .load_flags  (alu_flags_s),
    .rsp_ready   (rsp1_ready),
    .rsp_valid   (rsp1_valid),
    .rsp_result  (rsp1_result),
    .rsp_flags   (rsp1_flags)
  );

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational 32-bit ALU (module alu) between two requesters, e.g. the execute stage (port 0) and an address/iterative unit (port 1).
- Round-robin arbitration with valid/ready on the request side.
- One-entry registered response buffer per requester, with its own backpressure.
- Owns the architectural NZCV flag register, updated only by granted operations with setflags asserted.

Parameters:
- FLAG_INIT, 4'b0000, reset value of the NZCV register {N,Z,C,V}.
- FIRST_PRI, 0, requester that holds round-robin priority after reset (0 or 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  request N presents an operation (N = 0, 1; same for all reqN/rspN ports below).
- reqN_ready  out  1  request N accepted this cycle when valid & ready.
- reqN_a  in  32  operand A.
- reqN_b  in  32  operand B.
- reqN_op  in  2  ALU control: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- reqN_setflags  in  1  write the resulting NZCV into the flag register.
- rspN_valid  out  1  response N buffer holds a result.
- rspN_ready  in  1  consumer N takes the response.
- rspN_result  out  32  buffered ALU result.
- rspN_flags  out  4  buffered {N,Z,C,V} of that operation, regardless of setflags.
- flags  out  4  architectural NZCV register.
- busy  out  1  either response buffer occupied.

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - rsp0_valid, rsp1_valid = 0; rsp results and flags = 0.
  - flags = FLAG_INIT; rr priority pointer = FIRST_PRI; busy = 0.
  - Any in-flight buffered result is discarded.
- Eligibility: elig[i] = req_valid[i] & (~rsp_valid[i] | rsp_ready[i]). A full buffer accepts a new op in the same cycle it drains.
- Arbitration (combinational, one grant per cycle):
  - Only one eligible: grant it.
  - Both eligible: grant the requester indicated by the rr pointer.
  - req_ready[i] = grant[i]. ready may depend on valid; requesters must not make valid depend on ready.
- rr pointer update: on each accepted grant, pointer <= the other requester. With no grant, the pointer holds.
- ALU muxing: the granted requester's a/b/op drive the single alu instance. The mux defaults to requester 0 inputs when idle. The ALU output is ignored when no grant is made.
- Latency: accepted at rising edge k, so rspN_valid = 1 and result/flags are visible after edge k, i.e. one cycle.
- Response buffer i, evaluated per edge:
  - Accept: load and set valid.
  - Drain without accept: clear valid.
  - Drain and accept together: reload, valid stays 1.
  - Neither: hold. Result and flags are stable while valid & ~ready.
- Flag register:
  - On an accepted grant with setflags = 1, flags <= ALU flags at that edge.
  - Otherwise flags hold.
  - Only one op per cycle, so there are no write conflicts.
- ALU semantics are inherited unchanged:
  - C is bit 32 of the 33-bit add or subtract; for SUB that is the borrow, not ARM not-borrow.
  - V follows signed overflow.
  - AND/ORR force C = V = 0.
  - N = result[31]; Z = (result == 0).
- busy = rsp0_valid | rsp1_valid.
- Starvation: with both requesters continuously eligible, grants strictly alternate 0,1,0,1 (or 1,0,… per pointer).

Decomposition:
- Package alu_ctrl_pkg:
  - Op constants ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11.
  - Flag bit indices FLG_N = 3, FLG_Z = 2, FLG_C = 1, FLG_V = 0.
- Sub-modules:
  - Exactly one existing alu instance, unmodified.
  - One natural sub-module, alu_rsp_buf: one-entry result/flag buffer with valid/ready, instantiated twice.
  - The arbiter and flag register stay in the top.

Test Plan:
- Reset, then req0 ADD a = 0x7FFFFFFF, b = 0x00000001, setflags = 1 -> ready0 same cycle; next cycle rsp0_valid = 1, result = 0x80000000, rsp0_flags = 4'b1001, flags = 4'b1001.
- req1 SUB 5 - 5, setflags = 1 -> rsp1 result = 0x00000000, flags = 4'b0100. Then req1 SUB 3 - 5, setflags = 0 -> result = 0xFFFFFFFE, rsp1_flags = 4'b1010, flags still 4'b0100.
- Both valid continuously, both rsp_ready = 1, FIRST_PRI = 0, for 6 cycles -> grant order 0,1,0,1,0,1; each response arrives one cycle after its accept.
- rsp0_ready = 0 with rsp0 full:
  - req0 valid -> ready0 = 0 and req1 is granted every cycle.
  - Raise rsp0_ready -> req0 accepted the same cycle, rsp0_valid stays 1, result updates.
- Assert rst_n = 0 asynchronously mid-cycle while both buffers are full and flags = 4'b1001 -> rsp_valid = 0, flags = FLAG_INIT, busy = 0 without waiting for a clock edge. After release, the first contested grant goes to FIRST_PRI.
- AND 0xF0F0F0F0 & 0x0F0F0F0F with setflags = 1 -> result = 0, flags = 4'b0100; ORR 0x80000000 | 0 -> flags = 4'b1000.
